// File: rtl/alu_seq_datapath.sv
// alu_seq_datapath: DEPTH-slot operand bank feeding a sequenced ALU with a
// status-flag register, an accumulate op and an N-cycle shift-add multiplier.
// Strobes (ld, exec) are edge-detected internally so button levels give one
// action per press. The external reset asserts asynchronously and is released
// through a two-flop synchronizer.
// Optional build macro ALU_SAT_EN: ADD/ACC/SUB/MUL saturate instead of wrapping.
module alu_seq_datapath #(
  parameter int  N     = 8,
  parameter int  DEPTH = 4,
  localparam int SW    = $clog2(DEPTH),
  localparam int CW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          exec,
  input  logic [SW-1:0] sel,
  input  logic [N-1:0]  din,
  input  logic [3:0]    op,
  output logic [N-1:0]  bank_q,
  output logic [N-1:0]  result,
  output logic [3:0]    flags,
  output logic          busy,
  output logic          done
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;
  localparam logic [3:0] OP_ACC  = 4'd10;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic             rst_meta_r;
  logic             rst_sync_r;
  logic             ld_q_r;
  logic             exec_q_r;
  logic             ld_rise_s;
  logic             exec_rise_s;
  logic [N-1:0]     bank_r [DEPTH];
  state_t           state_r;
  logic [N-1:0]     in1_r;
  logic [N-1:0]     in0_r;
  logic [3:0]       op_r;
  logic [2*N-1:0]   prod_r;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     result_r;
  logic [3:0]       flags_r;
  logic             busy_r;
  logic             done_r;
  logic [N+3:0]     alu_out_s;
  logic [N:0]       mul_sum_s;
  logic [2*N-1:0]   mul_next_s;
  logic [N+3:0]     mul_out_s;

  // Single-cycle ALU: returns {Z,Nf,C,V,result}; unlisted ops keep the old state.
  function automatic logic [N+3:0] alu_eval(
    input logic [3:0]   op_v,
    input logic [N-1:0] a_v,
    input logic [N-1:0] b_v,
    input logic [N-1:0] acc_v,
    input logic [3:0]   flags_v
  );
    logic [N:0]   wide_v;
    logic [N-1:0] base_v;
    logic [N-1:0] r_v;
    logic         c_v;
    logic         v_v;
    logic         keep_v;
    wide_v = {(N+1){1'b0}};
    base_v = {N{1'b0}};
    r_v    = {N{1'b0}};
    c_v    = 1'b0;
    v_v    = 1'b0;
    keep_v = 1'b0;
    case (op_v)
      OP_ADD, OP_ACC: begin
        base_v = (op_v == OP_ACC) ? acc_v : a_v;
        wide_v = {1'b0, base_v} + {1'b0, b_v};
        r_v    = wide_v[N-1:0];
        c_v    = wide_v[N];
        v_v    = (base_v[N-1] == b_v[N-1]) && (r_v[N-1] != base_v[N-1]);
`ifdef ALU_SAT_EN
        r_v    = c_v ? {N{1'b1}} : r_v;
`endif
      end
      OP_SUB: begin
        r_v = a_v - b_v;
        c_v = (a_v < b_v);
        v_v = (a_v[N-1] != b_v[N-1]) && (r_v[N-1] != a_v[N-1]);
`ifdef ALU_SAT_EN
        r_v = c_v ? {N{1'b0}} : r_v;
`endif
      end
      OP_AND:  r_v = a_v & b_v;
      OP_OR:   r_v = a_v | b_v;
      OP_XOR:  r_v = a_v ^ b_v;
      OP_NOT:  r_v = ~a_v;
      OP_SLL: begin
        r_v = {a_v[N-2:0], 1'b0};
        c_v = a_v[N-1];
      end
      OP_SRL: begin
        r_v = {1'b0, a_v[N-1:1]};
        c_v = a_v[0];
      end
      OP_PASS: r_v = b_v;
      // MUL is sequenced elsewhere; codes 11-15 leave result and flags alone
      default: keep_v = 1'b1;
    endcase
    return keep_v ? {flags_v, acc_v}
                  : {(r_v == {N{1'b0}}), r_v[N-1], c_v, v_v, r_v};
  endfunction

  // Final multiplier result and flags from the full 2N-bit product.
  function automatic logic [N+3:0] mul_eval(input logic [2*N-1:0] prod_v);
    logic [N-1:0] r_v;
    logic         c_v;
    c_v = |prod_v[2*N-1:N];
    r_v = prod_v[N-1:0];
`ifdef ALU_SAT_EN
    r_v = c_v ? {N{1'b1}} : r_v;
`endif
    return {(r_v == {N{1'b0}}), r_v[N-1], c_v, c_v, r_v};
  endfunction

  assign bank_q = bank_r[sel];
  assign result = result_r;
  assign flags  = flags_r;
  assign busy   = busy_r;
  assign done   = done_r;

  // Reset synchronizer: assert immediately, release on the second clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Strobe edges and the next shift-add step / ALU outcome
  always_comb begin
    ld_rise_s   = ld & ~ld_q_r;
    exec_rise_s = exec & ~exec_q_r;
    alu_out_s   = alu_eval(op_r, in1_r, in0_r, result_r, flags_r);
    mul_sum_s   = {1'b0, prod_r[2*N-1:N]} +
                  (prod_r[0] ? {1'b0, in1_r} : {(N+1){1'b0}});
    mul_next_s  = {mul_sum_s, prod_r[N-1:1]};
    mul_out_s   = mul_eval(mul_next_s);
  end

  // Strobe history and operand bank writes on a rising ld, in any FSM state
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      ld_q_r   <= 1'b0;
      exec_q_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_r[i] <= {N{1'b0}};
      end
    end else begin
      ld_q_r   <= ld;
      exec_q_r <= exec;
      if (ld_rise_s) begin
        bank_r[sel] <= din;
      end
    end
  end

  // Operation sequencer: capture operands, run ALU or multiplier, pulse done
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r  <= ST_IDLE;
      in1_r    <= {N{1'b0}};
      in0_r    <= {N{1'b0}};
      op_r     <= 4'd0;
      prod_r   <= {(2*N){1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {N{1'b0}};
      flags_r  <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (exec_rise_s) begin
            // bank_r read here is the pre-edge value, even if ld rises too
            in1_r   <= bank_r[sel];
            in0_r   <= din;
            op_r    <= op;
            prod_r  <= {{N{1'b0}}, din};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          {flags_r, result_r} <= alu_out_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_MUL: begin
          prod_r <= mul_next_s;
          if (cnt_r == CNT_LAST) begin
            {flags_r, result_r} <= mul_out_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
